uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Parametrised UART receiver with a first-word-fall-through (FWFT) receive FIFO and sticky error flags.
- Captures serial traffic such as the chip's rs232_dce_txd line. Used both as a synthesizable peripheral front-end and as the capture transactor in chip-level benches.
- Generalises fixed 8N1 capture to configurable baud divider, data width, parity mode, stop bits and buffer depth.

Parameters:
CLKS_PER_BIT, 868, clocks per bit period (100 MHz / 115200); minimum 8
DATA_BITS, 8, data bits per frame, 5..9, LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 16, receive FIFO entries, power of 2, >= 2

Ports:
clk  in  1  system clock
reset_async  in  1  asynchronous active-high reset
rxd  in  1  serial input, idle high, asynchronous to clk
rd_en  in  1  pop request; honoured only while rd_valid=1
rd_data  out  DATA_BITS  FIFO head word, valid while rd_valid=1
rd_valid  out  1  FIFO non-empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
busy  out  1  receiver not in IDLE
err_clr  in  1  clears all sticky error flags
parity_err  out  1  sticky: parity mismatch seen
frame_err  out  1  sticky: stop bit sampled low
overrun_err  out  1  sticky: good frame dropped because FIFO full

Behaviour:
- Reset values: rd_data=0, rd_valid=0, fifo_count=0, busy=0, all error flags 0, synchroniser flops=1, FSM=IDLE.
- Reset asserted mid-frame abandons the frame and empties the FIFO.
- rxd passes through a 2-flop synchroniser (rxs). Edge detect uses rxs and its previous value.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: on a rxs falling edge, go to START and load the bit counter.
- START: sample at CLKS_PER_BIT/2 clocks after the edge.
  - rxs=1: glitch; return to IDLE with no error.
  - rxs=0: go to DATA.
- DATA: sample every CLKS_PER_BIT clocks, shift LSB first, DATA_BITS samples. Then go to PARITY if PARITY!=0, else STOP.
- PARITY: one sample.
  - Odd mode: error if XOR(data, pbit) != 1.
  - Even mode: error if XOR(data, pbit) != 0.
- STOP: sample STOP_BITS times at bit midpoints.
  - Any stop sample low: set frame_err, discard the frame, go to BREAK.
  - Otherwise, after the last stop sample: push if parity is OK, else set parity_err and discard. Return to IDLE in the same cycle.
  - Returning at the stop midpoint allows back-to-back frames with up to ±4% baud error.
- BREAK: wait for rxs=1, then go to IDLE. A line held low yields exactly one frame_err event.
- busy=1 in every state except IDLE.
- Push timing: decision at the final stop-sample cycle S. The FIFO write is registered at the edge ending S, so rd_valid, rd_data and fifo_count update from S+1.
- Push while full with no pop in the same cycle: word dropped, overrun_err set, FIFO contents unchanged.
- FIFO is FWFT: rd_data shows the head combinationally from the registered array.
- Pop on the rd_en && rd_valid edge; rd_data shows the next word from the following cycle.
- rd_en while empty is ignored; no underflow and no count change.
- Simultaneous push and pop:
  - Count unchanged; the push is accepted even when full.
  - If empty, no pop occurs and count becomes 1.
- Read and write pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.
- err_clr clears all flags on the next edge. An error event in the same cycle as err_clr wins: the flag is 1 after the edge.
- Parity/frame errors never push data.

Test Plan:
1. CLKS_PER_BIT=16, 8N1; send 0xA5 -> rd_valid=1 at S+1, rd_data=0xA5, fifo_count=1, all errors 0. Then rd_en for 1 cycle -> rd_valid=0, count=0.
2. PARITY=2; send 0x03 with parity bit 1 (correct is 0) -> parity_err=1, count=0. Then send 0x07 with parity bit 1 -> count=1, rd_data=0x07. Pulse err_clr -> parity_err=0.
3. Stop bit driven low for 0x55, line held low 40 bit times, then high -> frame_err=1, single event, count=0. Next frame 0x3C -> received correctly.
4. FIFO_DEPTH=16; send 17 bytes 0x00..0x10 back-to-back without reading -> count=16, overrun_err=1. 16 reads return 0x00..0x0F in order, then rd_valid=0.
5. Low glitch of 4 clocks on rxd -> busy pulses, returns to IDLE, no push, no error flags.
6. reset_async for 3 clocks after 3 data bits of a frame -> all outputs at reset values, FIFO empty. Following frame 0x5A is received correctly.
7. FIFO full with rd_en=1 in the push cycle S -> overrun_err stays 0, count stays 16, head advances by one.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (mid-bit sampling, optional parity, 1/2 stop bits) feeding a FWFT receive FIFO.
// A good frame is written on the edge ending its last stop sample; a push into a full FIFO is dropped unless a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset_async,
    input  logic                          rxd,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    input  logic                          err_clr,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overrun_err
);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int BW   = 4;
    localparam logic [CW-1:0] FULL_LD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic          ODD     = (PARITY == 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    state_t                 state, state_n;
    logic                   rx_meta, rxs, rxs_d;
    logic [CW-1:0]          cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bad, par_chk;
    logic                   smp, load_half, load_full, shift, par_smp, bit_inc;
    logic                   push, set_pe, set_fe, set_ov;
    logic                   pop, wr, full;
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];

    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    assign smp     = (cnt == '0);
    assign par_chk = (^{shreg, rxs}) ^ ODD;

    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) state <= S_IDLE;
        else             state <= state_n;
    end

    always_comb begin
        state_n   = state;
        load_half = 1'b0;
        load_full = 1'b0;
        shift     = 1'b0;
        par_smp   = 1'b0;
        bit_inc   = 1'b0;
        push      = 1'b0;
        set_pe    = 1'b0;
        set_fe    = 1'b0;
        case (state)
            S_IDLE: if (rxs_d && !rxs) begin
                state_n   = S_START;
                load_half = 1'b1;
            end
            S_START: if (smp) begin
                if (rxs) begin
                    state_n = S_IDLE;
                end else begin
                    state_n   = S_DATA;
                    load_full = 1'b1;
                end
            end
            S_DATA: if (smp) begin
                shift     = 1'b1;
                bit_inc   = 1'b1;
                load_full = 1'b1;
                if (bit_cnt == BW'(DATA_BITS - 1))
                    state_n = (PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (smp) begin
                par_smp   = 1'b1;
                load_full = 1'b1;
                state_n   = S_STOP;
            end
            S_STOP: if (smp) begin
                // Leaving at the stop midpoint leaves half a bit of slack for the next start edge.
                if (!rxs) begin
                    set_fe  = 1'b1;
                    state_n = S_BREAK;
                end else if (bit_cnt == BW'(STOP_BITS - 1)) begin
                    state_n = S_IDLE;
                    if (par_bad) set_pe = 1'b1;
                    else         push   = 1'b1;
                end else begin
                    bit_inc   = 1'b1;
                    load_full = 1'b1;
                end
            end
            S_BREAK: if (rxs) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bad <= 1'b0;
        end else begin
            if (load_half)       cnt <= HALF_LD;
            else if (load_full)  cnt <= FULL_LD;
            else if (cnt != '0)  cnt <= cnt - CW'(1);

            if (state_n != state) bit_cnt <= '0;
            else if (bit_inc)     bit_cnt <= bit_cnt + BW'(1);

            if (shift) shreg <= {rxs, shreg[DATA_BITS-1:1]};

            if (load_half)    par_bad <= 1'b0;
            else if (par_smp) par_bad <= par_chk;
        end
    end

    assign busy     = (state != S_IDLE);
    assign rd_valid = (fifo_count != '0);
    assign full     = (fifo_count == CNTW'(FIFO_DEPTH));
    assign pop      = rd_en && rd_valid;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign wr       = push && (!full || pop);
    assign set_ov   = push && full && !pop;
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({wr, pop})
                2'b10:   fifo_count <= fifo_count + CNTW'(1);
                2'b01:   fifo_count <= fifo_count - CNTW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            parity_err  <= set_pe | (parity_err  & ~err_clr);
            frame_err   <= set_fe | (frame_err   & ~err_clr);
            overrun_err <= set_ov | (overrun_err & ~err_clr);
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: an 8N1 instance (a) and an 8E2 instance with a 4-deep FIFO (b).
module tb_uart_rx_fifo;
    localparam int CPB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rxd_a, rd_en_a, clr_a;
    logic [7:0] rd_data_a;
    logic       rd_valid_a, busy_a, pe_a, fe_a, ov_a;
    logic [4:0] count_a;
    logic       rxd_b, rd_en_b, clr_b;
    logic [7:0] rd_data_b;
    logic       rd_valid_b, busy_b, pe_b, fe_b, ov_b;
    logic [2:0] count_b;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut_a (
        .clk(clk), .reset_async(rst), .rxd(rxd_a), .rd_en(rd_en_a), .rd_data(rd_data_a),
        .rd_valid(rd_valid_a), .fifo_count(count_a), .busy(busy_a), .err_clr(clr_a),
        .parity_err(pe_a), .frame_err(fe_a), .overrun_err(ov_a));

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .reset_async(rst), .rxd(rxd_b), .rd_en(rd_en_b), .rd_data(rd_data_b),
        .rd_valid(rd_valid_b), .fifo_count(count_b), .busy(busy_b), .err_clr(clr_b),
        .parity_err(pe_b), .frame_err(fe_b), .overrun_err(ov_b));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d;
        logic       pb;
        logic       s1;
        logic       s2;
        logic       push;
        logic       pe;
        logic       fe;
    } vec_t;
    vec_t vt[7];

    logic [7:0] q[$];
    logic       ov_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_rxd(input int w, input logic v);
        if (w == 0) rxd_a = v;
        else        rxd_b = v;
    endtask

    // Start bit, 8 data bits LSB first, optional parity bit; the caller drives the stop bits.
    task automatic frame_head(input int w, input logic [7:0] d, input bit has_par, input logic pb);
        drive_rxd(w, 1'b0);
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            drive_rxd(w, d[i]);
            tick(CPB);
        end
        if (has_par) begin
            drive_rxd(w, pb);
            tick(CPB);
        end
    endtask

    task automatic send_a(input logic [7:0] d);
        frame_head(0, d, 1'b0, 1'b0);
        drive_rxd(0, 1'b1);
        tick(CPB);
    endtask

    task automatic pop_a(output logic [7:0] d);
        d = rd_data_a;
        rd_en_a = 1'b1;
        tick(1);
        rd_en_a = 1'b0;
    endtask

    task automatic pop_b(output logic [7:0] d);
        d = rd_data_b;
        rd_en_b = 1'b1;
        tick(1);
        rd_en_b = 1'b0;
    endtask

    task automatic pulse_clr_a();
        clr_a = 1'b1;
        tick(1);
        clr_a = 1'b0;
    endtask

    task automatic pulse_clr_b();
        clr_b = 1'b1;
        tick(1);
        clr_b = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        bit         saw_busy;

        // Even parity: bit makes the total number of ones even.
        vt[0] = '{8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[1] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[2] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[3] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[4] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[5] = '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[6] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        rxd_a = 1'b1; rd_en_a = 1'b0; clr_a = 1'b0;
        rxd_b = 1'b1; rd_en_b = 1'b0; clr_b = 1'b0;
        tick(3);
        check("reset_valid", 32'(rd_valid_a), 0);
        check("reset_count", 32'(count_a), 0);
        check("reset_busy", 32'(busy_a), 0);
        check("reset_flags", 32'({pe_a, fe_a, ov_a}), 0);
        check("reset_data", 32'(rd_data_a), 0);
        rst = 1'b0;
        tick(5);

        // Single 8N1 frame: write lands one cycle after the stop sample.
        frame_head(0, 8'hA5, 1'b0, 1'b0);
        drive_rxd(0, 1'b1);
        tick(10);
        check("t1_valid_at_S", 32'(rd_valid_a), 0);
        tick(1);
        check("t1_valid_S1", 32'(rd_valid_a), 1);
        check("t1_data", 32'(rd_data_a), 32'h A5);
        check("t1_count", 32'(count_a), 1);
        check("t1_busy", 32'(busy_a), 0);
        check("t1_flags", 32'({pe_a, fe_a, ov_a}), 0);
        tick(CPB - 11);
        pop_a(d);
        check("t1_pop_valid", 32'(rd_valid_a), 0);
        check("t1_pop_count", 32'(count_a), 0);

        // Parity / stop-bit table on the 8E2 instance.
        for (int i = 0; i < 7; i++) begin
            pulse_clr_b();
            frame_head(1, vt[i].d, 1'b1, vt[i].pb);
            drive_rxd(1, vt[i].s1);
            tick(CPB);
            drive_rxd(1, vt[i].s2);
            tick(CPB);
            drive_rxd(1, 1'b1);
            tick(2 * CPB);
            check($sformatf("vec%0d_count", i), 32'(count_b), 32'(vt[i].push));
            check($sformatf("vec%0d_pe", i), 32'(pe_b), 32'(vt[i].pe));
            check($sformatf("vec%0d_fe", i), 32'(fe_b), 32'(vt[i].fe));
            if (vt[i].push) begin
                pop_b(d);
                check($sformatf("vec%0d_data", i), 32'(d), 32'(vt[i].d));
            end
            pulse_clr_b();
            check($sformatf("vec%0d_clr", i), 32'({pe_b, fe_b, count_b}), 0);
        end

        // Error event coinciding with err_clr must leave the flag set.
        frame_head(1, 8'h03, 1'b1, 1'b1);
        drive_rxd(1, 1'b1);
        tick(CPB);
        tick(10);
        clr_b = 1'b1;
        tick(1);
        clr_b = 1'b0;
        check("race_pe", 32'(pe_b), 1);
        tick(2 * CPB);
        pulse_clr_b();
        check("race_clr", 32'(pe_b), 0);

        // Stop bit low followed by a long break: one frame error only.
        frame_head(0, 8'h55, 1'b0, 1'b0);
        drive_rxd(0, 1'b0);
        tick(CPB);
        check("t3_fe", 32'(fe_a), 1);
        check("t3_busy", 32'(busy_a), 1);
        tick(20 * CPB);
        pulse_clr_a();
        tick(19 * CPB);
        check("t3_single_event", 32'(fe_a), 0);
        check("t3_busy_break", 32'(busy_a), 1);
        drive_rxd(0, 1'b1);
        tick(2 * CPB);
        check("t3_idle", 32'({busy_a, fe_a, count_a}), 0);
        send_a(8'h3C);
        check("t3_next_count", 32'(count_a), 1);
        pop_a(d);
        check("t3_next_data", 32'(d), 32'h3C);

        // Short low glitch is rejected at the start-bit midpoint.
        drive_rxd(0, 1'b0);
        tick(4);
        drive_rxd(0, 1'b1);
        saw_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (busy_a) saw_busy = 1'b1;
        end
        check("t5_busy_pulse", 32'(saw_busy), 1);
        check("t5_idle", 32'({busy_a, pe_a, fe_a, ov_a, count_a}), 0);

        // Overrun: 17 back-to-back frames into a 16-deep FIFO.
        for (int i = 0; i <= 16; i++) send_a(8'(i));
        check("t4_count", 32'(count_a), 16);
        check("t4_ov", 32'(ov_a), 1);
        for (int i = 0; i < 16; i++) begin
            pop_a(d);
            check($sformatf("t4_rd%0d", i), 32'(d), 32'(i));
        end
        check("t4_empty", 32'(rd_valid_a), 0);
        pulse_clr_a();
        check("t4_clr", 32'(ov_a), 0);

        // Full FIFO with a pop in the push cycle: push accepted, no overrun.
        for (int i = 0; i < 16; i++) send_a(8'(8'h40 + i));
        check("t7_full", 32'(count_a), 16);
        frame_head(0, 8'hEE, 1'b0, 1'b0);
        drive_rxd(0, 1'b1);
        tick(10);
        rd_en_a = 1'b1;
        tick(1);
        rd_en_a = 1'b0;
        check("t7_ov", 32'(ov_a), 0);
        check("t7_count", 32'(count_a), 16);
        check("t7_head", 32'(rd_data_a), 32'h41);
        tick(CPB - 11);
        for (int i = 1; i < 16; i++) begin
            pop_a(d);
            check($sformatf("t7_rd%0d", i), 32'(d), 32'(8'h40 + i));
        end
        pop_a(d);
        check("t7_last", 32'(d), 32'hEE);
        check("t7_empty", 32'(rd_valid_a), 0);

        // Reset in the middle of a frame with a word already buffered.
        send_a(8'h11);
        drive_rxd(0, 1'b0);
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            drive_rxd(0, i[0]);
            tick(CPB);
        end
        check("t6_pre_busy", 32'(busy_a), 1);
        check("t6_pre_count", 32'(count_a), 1);
        rst = 1'b1;
        drive_rxd(0, 1'b1);
        tick(3);
        check("t6_rst_outputs", 32'({rd_valid_a, busy_a, pe_a, fe_a, ov_a, count_a}), 0);
        check("t6_rst_data", 32'(rd_data_a), 0);
        rst = 1'b0;
        tick(2 * CPB);
        check("t6_post_idle", 32'({busy_a, count_a}), 0);
        send_a(8'h5A);
        check("t6_count", 32'(count_a), 1);
        pop_a(d);
        check("t6_data", 32'(d), 32'h5A);

        // Random frames and reads against a queue model.
        ov_m = 1'b0;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(2, 0) != 0) begin
                d = 8'($urandom);
                send_a(d);
                if (q.size() < 16) q.push_back(d);
                else               ov_m = 1'b1;
            end else begin
                logic [7:0] got;
                if (q.size() > 0) begin
                    pop_a(got);
                    check($sformatf("rnd%0d_data", it), 32'(got), 32'(q[0]));
                    void'(q.pop_front());
                end else begin
                    pop_a(got);
                end
            end
            check($sformatf("rnd%0d_count", it), 32'(count_a), 32'(q.size()));
            check($sformatf("rnd%0d_ov", it), 32'(ov_a), 32'(ov_m));
        end
        while (q.size() > 0) begin
            pop_a(d);
            check("rnd_drain", 32'(d), 32'(q[0]));
            void'(q.pop_front());
        end
        check("rnd_empty", 32'(rd_valid_a), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
